scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder.sv | 101 ++++++++++
 tb/tb_scan_decoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
// Module : scan_decoder
// Desc   : N-to-2**N one-hot decoder with direct mode and masked auto-scan.
// Rev    : 1.0  initial release
// ============================================================================
module scan_decoder #(
    parameter int N      = 3,
    parameter int PERIOD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      in,
    input  logic              load,
    input  logic [2**N-1:0]   mask,
    output logic [2**N-1:0]   out,
    output logic [N-1:0]      idx,
    output logic              wrap
);
    localparam int CH = 2**N;
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    next_idx;
    logic [N-1:0]    cand;
    logic            next_found;
    logic [CH-1:0]   dec_in;
    logic [CH-1:0]   dec_idx;
    logic [CH-1:0]   dec_next;

    // Walk candidates farthest-first so the nearest one after idx wins;
    // distance CH lands on idx itself and is therefore the last resort.
    always_comb begin
        next_idx   = idx;
        next_found = 1'b0;
        cand       = idx;
        for (int k = CH; k >= 1; k--) begin
            cand = idx + N'(k);
            if (mask[cand]) begin
                next_idx   = cand;
                next_found = 1'b1;
            end
        end
    end

    assign dec_in   = CH'(1) << in;
    assign dec_idx  = CH'(1) << idx;
    assign dec_next = CH'(1) << next_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            out   <= '0;
            idx   <= '0;
            wrap  <= 1'b0;
            cnt   <= '0;
        end else begin
            wrap <= 1'b0;
            if (!en) begin
                state <= IDLE;
                out   <= '0;
                cnt   <= '0;
            end else if (!mode) begin
                state <= DIRECT;
                out   <= dec_in;
                idx   <= in;
                cnt   <= '0;
            end else begin
                state <= SCAN;
                if (state != SCAN || load) begin
                    idx <= in;
                    cnt <= '0;
                    out <= dec_in & mask;
                end else if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    if (next_found) begin
                        idx  <= next_idx;
                        out  <= dec_next & mask;
                        wrap <= (next_idx <= idx);
                    end else begin
                        out  <= '0;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                    out <= dec_idx & mask;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// Testbench for scan_decoder: scoreboard queue fed by a channel-list model.
module tb_scan_decoder;
    localparam int N      = 3;
    localparam int PERIOD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] in = '0;
    logic       load = 1'b0;
    logic [7:0] mask = '0;
    logic [7:0] out;
    logic [2:0] idx;
    logic       wrap;

    scan_decoder #(.N(N), .PERIOD(PERIOD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in),
        .load(load), .mask(mask), .out(out), .idx(idx), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] out;
        logic [2:0] idx;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;
    int   cycle  = 0;

    // Reference state
    bit   m_scan = 0;
    int   m_idx  = 0;
    int   m_cnt  = 0;

    // Next active channel: smallest active index above cur, else the smallest
    // active index overall (which is the wrap case). -1 when nothing is active.
    function automatic int next_active(input int cur, input bit [7:0] m);
        int above = -1;
        int lowest = -1;
        for (int c = 7; c >= 0; c--) begin
            if (m[c]) begin
                lowest = c;
                if (c > cur) above = c;
            end
        end
        return (above >= 0) ? above : lowest;
    endfunction

    task automatic step(input bit r, input bit e, input bit md, input int i,
                        input bit ld, input bit [7:0] m);
        exp_t x;
        int   j;
        @(negedge clk);
        rst_n = r; en = e; mode = md; in = 3'(i); load = ld; mask = m;
        x.wrap = 1'b0;
        if (!r) begin
            m_scan = 0; m_idx = 0; m_cnt = 0; x.out = 8'd0;
        end else if (!e) begin
            m_scan = 0; m_cnt = 0; x.out = 8'd0;
        end else if (!md) begin
            m_scan = 0; m_cnt = 0; m_idx = i; x.out = 8'd1 << i;
        end else if (!m_scan || ld) begin
            m_scan = 1; m_cnt = 0; m_idx = i;
            x.out = m[i] ? (8'd1 << i) : 8'd0;
        end else if (m_cnt == PERIOD - 1) begin
            m_cnt = 0;
            j = next_active(m_idx, m);
            if (j < 0) begin
                x.out = 8'd0;
            end else begin
                x.wrap = (j <= m_idx);
                m_idx  = j;
                x.out  = 8'd1 << j;
            end
        end else begin
            m_cnt = m_cnt + 1;
            x.out = m[m_idx] ? (8'd1 << m_idx) : 8'd0;
        end
        x.idx = 3'(m_idx);
        exp_q.push_back(x);
    endtask

    // Monitor: one expected entry per clock edge after stimulus began
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                tests++;
                if (out !== x.out || idx !== x.idx || wrap !== x.wrap ||
                    $countones(out) > 1) begin
                    failed++;
                    $display("FAIL cycle %0d out/idx/wrap: got %b/%0d/%b expected %b/%0d/%b",
                             cycle, out, idx, wrap, x.out, x.idx, x.wrap);
                end
            end
        end
    end

    initial begin
        int guard;
        // Reset held with scan requested
        repeat (2) step(0, 1, 1, 5, 0, 8'hFF);
        // Direct sweep then disable
        for (int i = 0; i < 8; i++) step(1, 1, 0, i, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        // Scan with gaps
        repeat (20) step(1, 1, 1, 0, 0, 8'b1010_0101);
        step(1, 0, 1, 0, 0, 8'b1010_0101);
        // Single channel, then empty mask
        repeat (13) step(1, 1, 1, 4, 0, 8'b0001_0000);
        repeat (6) step(1, 1, 1, 4, 0, 8'h00);
        // Load colliding with an advance
        step(1, 0, 0, 0, 0, 8'hFF);
        step(1, 1, 1, 0, 0, 8'hFF);
        guard = 0;
        while (m_cnt != PERIOD - 1 && guard < 16) begin
            step(1, 1, 1, 0, 0, 8'hFF); guard++;
        end
        step(1, 1, 1, 6, 1, 8'hFF);
        repeat (9) step(1, 1, 1, 0, 0, 8'hFF);
        // Mid-scan reset at idx 5
        step(1, 1, 0, 0, 0, 8'hFF);
        step(1, 1, 1, 0, 0, 8'hFF);
        guard = 0;
        while (m_idx != 5 && guard < 64) begin
            step(1, 1, 1, 0, 0, 8'hFF); guard++;
        end
        step(0, 1, 1, 0, 0, 8'hFF);
        repeat (6) step(1, 1, 1, 3, 0, 8'hFF);
        // Randomized traffic
        begin
            bit [7:0] rm = 8'($urandom);
            for (int k = 0; k < 600; k++) begin
                if ($urandom_range(0, 7) == 0) rm = 8'($urandom);
                if ($urandom_range(0, 15) == 0) rm = 8'd1 << $urandom_range(0, 7);
                step(($urandom_range(0, 63) != 0),
                     ($urandom_range(0, 15) != 0),
                     ($urandom_range(0, 7) != 0),
                     int'($urandom_range(0, 7)),
                     ($urandom_range(0, 9) == 0),
                     rm);
            end
        end
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
`default_nettype wire
